blob_locator: RTL and testbench
===============================

# blob_locator

Frame-rate object locator: consumes the same pixel stream and `hcount`/`vcount` raster coordinates that the sprite renderers drive, and recovers the bounding box of all pixels that exactly match a target colour. Once per frame it publishes x/y/width/height, a pixel count and a found flag. These results feed straight back into a renderer's `x_in`/`y_in`, for example to overlay a box on a tracked object. Sits downstream of the camera/pixel mux, in the pixel clock domain.

## Interface

Parameters:

- `COLOR`, 12'hFFF, target RGB444 value; only exact matches count.
- `H_ACTIVE`, 1024, active pixels per line; only `hcount_in < H_ACTIVE` is accumulated.
- `V_ACTIVE`, 768, active lines; only `vcount_in < V_ACTIVE` is accumulated.
- `MIN_PIXELS`, 16, minimum matching-pixel count for `found_out=1`.

Ports:

- `clk_in` input 1: pixel clock; the only clock.
- `rst_in` input 1: reset, synchronous and active-low.
- `hcount_in` input 11: current pixel column.
- `vcount_in` input 10: current pixel row.
- `pixel_in` input 12: RGB444 pixel at (`hcount_in`, `vcount_in`).
- `x_out` output 11: leftmost matching column of the last complete frame.
- `y_out` output 10: topmost matching row.
- `width_out` output 11: max_x − min_x + 1.
- `height_out` output 10: max_y − min_y + 1.
- `count_out` output 20: matching pixels in the last frame, saturating at 20'hFFFFF.
- `found_out` output 1: `count_out >= MIN_PIXELS`.
- `valid_out` output 1: one-cycle pulse when the outputs above update.

## Operation

- **Frame-start event (FS):** a rising edge sees `hcount_in==0 && vcount_in==0`, and the previous cycle did not. FS is edge-detected, so holding (0,0) for N cycles yields one FS.
- **Match:** `pixel_in==COLOR` and the coordinate is inside the active area.
- **Accumulators:** `min_x`, `max_x`, `min_y`, `max_y`, `cnt`.
  - Initialised to min = all-ones, max = 0, cnt = 0.
  - On each match: min/max update, cnt increments, saturating.
- **States:**
  - **IDLE:** entered on reset. Ignores pixels and waits for FS. On FS, initialises the accumulators, folds in the (0,0) pixel, and moves to ACCUM. No `valid_out`.
  - **ACCUM:** accumulates matches.
    - On FS: latch the results to the outputs and pulse `valid_out`.
    - In the same edge, re-initialise the accumulators and fold in the (0,0) pixel as the first pixel of the new frame.
- **Latched results:**
  - If `cnt >= MIN_PIXELS`: `x_out=min_x`, `y_out=min_y`, `width_out=max_x-min_x+1`, `height_out=max_y-min_y+1`, `found_out=1`.
  - Otherwise `x_out`, `y_out`, `width_out` and `height_out` are 0 and `found_out=0`. `count_out` always shows the true saturated count.
- **Matching regions:** multiple disjoint regions produce their union bounding box.
- **Arithmetic:** all unsigned. Width and height never wrap, because they are computed only when cnt ≥ 1 (guaranteed by MIN_PIXELS ≥ 1; MIN_PIXELS=0 is illegal).

## Timing

- **Reset:** reset values apply on the clock edge where `rst_in==0`.
  - All outputs 0 and state IDLE.
  - The edge detector's previous-(0,0) flag is cleared, so (0,0) held through reset release produces an FS on the first edge after release.
- **Reset mid-frame:** the partial frame is discarded. The first `valid_out` comes at the second FS after release.
- **Latency:** outputs and `valid_out` are registered on the FS edge.
  - They are visible in the cycle immediately after that edge.
  - `valid_out` is high for exactly one cycle; outputs hold until the next FS.
- **Raster order:** no ordering is assumed beyond FS. A short frame or missing rows simply produce fewer samples.
- **Non-active coordinates** (blanking) never match, regardless of `pixel_in`.

## Test plan

- **Single rectangle:** blob renderer at x=100, y=50, 64×64, COLOR=12'hFFF, one full 1344×806 raster, then FS.
  - Expect `x_out=100`, `y_out=50`, `width_out=64`, `height_out=64`, `count_out=4096`, `found_out=1`.
  - Expect `valid_out` high for exactly one cycle.
- **Empty frame:** all pixels 0.
  - Expect `count_out=0`, `found_out=0`, x/y/width/height all 0, and `valid_out` still pulses.
- **Corner pixel with MIN_PIXELS=1:** only (1023,767) matches, and (1100,100) is also COLOR, in blanking.
  - Expect `x_out=1023`, `y_out=767`, width and height 1, `count_out=1`.
- **Union box:** two 8×8 boxes at (10,10) and (200,300).
  - Expect `x_out=10`, `y_out=10`, `width_out=198`, `height_out=298`, `count_out=128`.
- **Reset mid-frame:** assert `rst_in=0` at row 400 for 3 cycles.
  - Expect all outputs 0 immediately.
  - Expect no `valid_out` at the next FS; first valid at the following FS, with a correct box.
- **Held (0,0):** hold (0,0) for 5 cycles at frame start.
  - Expect exactly one `valid_out` pulse.
  - Expect the (0,0) pixel counted once into the new frame.

Source files
------------

// File: rtl/blob_locator.sv
// blob_locator: per-frame bounding box, pixel count and found flag for all
// active-area pixels that exactly match COLOR. Results are published on each
// frame-start edge, i.e. when the raster wraps back to (0,0).
module blob_locator #(
    parameter logic [11:0] COLOR      = 12'hFFF,
    parameter int          H_ACTIVE   = 1024,
    parameter int          V_ACTIVE   = 768,
    parameter int          MIN_PIXELS = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [11:0] pixel_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic [10:0] width_out,
    output logic [9:0]  height_out,
    output logic [19:0] count_out,
    output logic        found_out,
    output logic        valid_out
);

    localparam logic [10:0] H_LIM   = 11'(H_ACTIVE);
    localparam logic [9:0]  V_LIM   = 10'(V_ACTIVE);
    localparam logic [19:0] MIN_CNT = 20'(MIN_PIXELS);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t      state_q;
    logic        origin_q;

    logic [10:0] min_x_q, min_x_d;
    logic [10:0] max_x_q, max_x_d;
    logic [9:0]  min_y_q, min_y_d;
    logic [9:0]  max_y_q, max_y_d;
    logic [19:0] cnt_q,   cnt_d;

    logic        at_origin;
    logic        frame_start;
    logic        in_active;
    logic        hit;
    logic        sample_en;
    logic        publish;

    // Count increment that sticks at all-ones instead of wrapping.
    function automatic logic [19:0] sat_inc(input logic [19:0] c);
        return (c == 20'hFFFFF) ? c : c + 20'd1;
    endfunction

    // Inclusive extent between two coordinates; callers guarantee hi >= lo.
    function automatic logic [10:0] span_x(input logic [10:0] lo, input logic [10:0] hi);
        return hi - lo + 11'd1;
    endfunction

    function automatic logic [9:0] span_y(input logic [9:0] lo, input logic [9:0] hi);
        return hi - lo + 10'd1;
    endfunction

    assign at_origin   = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    // Edge-detected so that a raster parked on (0,0) yields one frame start.
    assign frame_start = at_origin && !origin_q;
    assign in_active   = (hcount_in < H_LIM) && (vcount_in < V_LIM);
    assign hit         = in_active && (pixel_in == COLOR);
    // Repeats of a held (0,0) are the same pixel already folded at frame start.
    assign sample_en   = frame_start || ((state_q == ACCUM) && !(at_origin && origin_q));
    assign publish     = frame_start && (state_q == ACCUM);

    // Next accumulator values: restart on frame start, then fold in this pixel.
    always_comb begin
        min_x_d = min_x_q;
        max_x_d = max_x_q;
        min_y_d = min_y_q;
        max_y_d = max_y_q;
        cnt_d   = cnt_q;
        if (frame_start) begin
            min_x_d = '1;
            max_x_d = '0;
            min_y_d = '1;
            max_y_d = '0;
            cnt_d   = '0;
        end
        if (sample_en && hit) begin
            if (hcount_in < min_x_d) min_x_d = hcount_in;
            if (hcount_in > max_x_d) max_x_d = hcount_in;
            if (vcount_in < min_y_d) min_y_d = vcount_in;
            if (vcount_in > max_y_d) max_y_d = vcount_in;
            cnt_d = sat_inc(cnt_d);
        end
    end

    // Accumulator registers; only meaningful once a frame start has been seen.
    always_ff @(posedge clk_in) begin
        min_x_q <= min_x_d;
        max_x_q <= max_x_d;
        min_y_q <= min_y_d;
        max_y_q <= max_y_d;
        cnt_q   <= cnt_d;
    end

    // Control FSM with registered result outputs latched at each frame start.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            origin_q   <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
            width_out  <= '0;
            height_out <= '0;
            count_out  <= '0;
            found_out  <= 1'b0;
            valid_out  <= 1'b0;
        end else begin
            origin_q  <= at_origin;
            valid_out <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (frame_start) state_q <= ACCUM;
                end
                ACCUM: begin
                    if (publish) begin
                        valid_out <= 1'b1;
                        count_out <= cnt_q;
                        if (cnt_q >= MIN_CNT) begin
                            x_out      <= min_x_q;
                            y_out      <= min_y_q;
                            width_out  <= span_x(min_x_q, max_x_q);
                            height_out <= span_y(min_y_q, max_y_q);
                            found_out  <= 1'b1;
                        end else begin
                            x_out      <= '0;
                            y_out      <= '0;
                            width_out  <= '0;
                            height_out <= '0;
                            found_out  <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blob_locator.sv
// Directed bench for blob_locator: two instances share one pixel stream, one
// with the default threshold and one with MIN_PIXELS=1.
module tb_blob_locator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic [11:0] pix = '0;

    logic [10:0] x0, w0, x1, w1;
    logic [9:0]  y0, h0, y1, h1;
    logic [19:0] c0, c1;
    logic        f0, v0, f1, v1;

    int errors = 0;
    int checks = 0;
    int npulse = 0;

    blob_locator u_dut (
        .clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
        .pixel_in(pix), .x_out(x0), .y_out(y0), .width_out(w0), .height_out(h0),
        .count_out(c0), .found_out(f0), .valid_out(v0)
    );

    blob_locator #(.MIN_PIXELS(1)) u_dut1 (
        .clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
        .pixel_in(pix), .x_out(x1), .y_out(y1), .width_out(w1), .height_out(h1),
        .count_out(c1), .found_out(f1), .valid_out(v1)
    );

    always #5 clk = ~clk;

    // Count cycles with valid_out high on the default instance.
    always @(posedge clk) if (v0 === 1'b1) npulse++;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_box(input string tag, input int sel, input int x, input int y,
                           input int w, input int h, input int c, input int f);
        if (sel == 0) begin
            check({tag, "_x"}, x0, x); check({tag, "_y"}, y0, y);
            check({tag, "_w"}, w0, w); check({tag, "_h"}, h0, h);
            check({tag, "_cnt"}, c0, c); check({tag, "_found"}, f0, f);
        end else begin
            check({tag, "_x1"}, x1, x); check({tag, "_y1"}, y1, y);
            check({tag, "_w1"}, w1, w); check({tag, "_h1"}, h1, h);
            check({tag, "_cnt1"}, c1, c); check({tag, "_found1"}, f1, f);
        end
    endtask

    task automatic px(input logic [10:0] h, input logic [9:0] v, input logic [11:0] p);
        hcount = h;
        vcount = v;
        pix    = p;
        @(posedge clk);
        #1;
    endtask

    task automatic rect(input int x, input int y, input int w, input int h);
        for (int j = 0; j < h; j++)
            for (int i = 0; i < w; i++)
                px(11'(x + i), 10'(y + j), 12'hFFF);
    endtask

    initial begin
        // Reset state
        px(11'd5, 10'd5, 12'h000);
        px(11'd5, 10'd5, 12'h000);
        chk_box("reset", 0, 0, 0, 0, 0, 0, 0);
        check("reset_valid", v0, 0);
        rst = 1'b1;

        // First frame start leaves IDLE without publishing
        px(11'd0, 10'd0, 12'h000);
        check("prime_valid", v0, 0);

        // Single 64x64 rectangle at (100,50), plus matching pixels in blanking
        px(11'd7, 10'd0, 12'h000);
        rect(100, 50, 64, 64);
        px(11'd1200, 10'd60, 12'hFFF);
        px(11'd150, 10'd790, 12'hFFF);
        px(11'd0, 10'd0, 12'h000);
        check("rect_valid", v0, 1);
        chk_box("rect", 0, 100, 50, 64, 64, 4096, 1);
        chk_box("rect", 1, 100, 50, 64, 64, 4096, 1);
        px(11'd1, 10'd0, 12'h000);
        check("rect_valid_drop", v0, 0);
        check("rect_hold_x", x0, 100);

        // Empty frame
        px(11'd5, 10'd5, 12'h000);
        px(11'd900, 10'd700, 12'h123);
        px(11'd0, 10'd0, 12'h000);
        check("empty_valid", v0, 1);
        chk_box("empty", 0, 0, 0, 0, 0, 0, 0);

        // Corner pixel; other matches lie in horizontal/vertical blanking
        px(11'd1023, 10'd767, 12'hFFF);
        px(11'd1100, 10'd100, 12'hFFF);
        px(11'd1023, 10'd768, 12'hFFF);
        px(11'd1024, 10'd5, 12'hFFF);
        px(11'd0, 10'd0, 12'h000);
        check("corner_valid", v0, 1);
        chk_box("corner", 1, 1023, 767, 1, 1, 1, 1);
        chk_box("corner", 0, 0, 0, 0, 0, 1, 0);

        // Union of two 8x8 boxes; frame ends on a held, matching (0,0)
        rect(10, 10, 8, 8);
        rect(200, 300, 8, 8);
        px(11'd0, 10'd0, 12'hFFF);
        check("union_valid", v0, 1);
        chk_box("union", 0, 10, 10, 198, 298, 128, 1);
        for (int k = 0; k < 4; k++) begin
            px(11'd0, 10'd0, 12'hFFF);
            check("held_valid", v0, 0);
        end
        px(11'd3, 10'd4, 12'hFFF);
        px(11'd0, 10'd0, 12'h000);
        check("held_frame_valid", v0, 1);
        chk_box("held", 0, 0, 0, 0, 0, 2, 0);
        chk_box("held", 1, 0, 0, 4, 5, 2, 1);

        // Reset mid-frame
        px(11'd20, 10'd20, 12'hFFF);
        rst = 1'b0;
        px(11'd30, 10'd400, 12'hFFF);
        chk_box("midrst", 0, 0, 0, 0, 0, 0, 0);
        check("midrst_valid", v0, 0);
        px(11'd30, 10'd400, 12'hFFF);
        px(11'd30, 10'd400, 12'hFFF);
        rst = 1'b1;
        px(11'd40, 10'd401, 12'hFFF);
        px(11'd0, 10'd0, 12'h000);
        check("midrst_fs1_valid", v0, 0);
        px(11'd1, 10'd0, 12'h000);
        rect(500, 600, 4, 4);
        px(11'd0, 10'd0, 12'h000);
        check("midrst_fs2_valid", v0, 1);
        chk_box("midrst_box", 0, 500, 600, 4, 4, 16, 1);
        px(11'd1, 10'd0, 12'h000);
        check("midrst_valid_drop", v0, 0);

        // Every publish was a single-cycle pulse
        px(11'd2, 10'd0, 12'h000);
        check("pulse_count", npulse, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
